// File: rtl/hdmi_axil_pkg.sv
// hdmi_axil_pkg: AXI response codes, master FSM states and the HDMI IP register map.
package hdmi_axil_pkg;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;
  typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP} state_e;
  localparam logic [11:0] CTRL_REG       = 12'h000;
  localparam logic [11:0] FIR_COEF_BASE  = 12'h010;
  localparam logic [11:0] HIST_BIN_BASE  = 12'h100;
  localparam int          HIST_BIN_COUNT = 256;
endpackage

// File: rtl/hdmi_axil_cfg_master_if.sv
// hdmi_axil_cfg_master_if: AXI4-Lite bus between the config master and the HDMI IP register slave.
interface hdmi_axil_cfg_master_if #(parameter int ADDR_W = 12);
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid, awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid, wready;
  logic [1:0]        bresp;
  logic              bvalid, bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid, arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid, rready;
  modport master(
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );
  modport slave(
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/hdmi_axil_cfg_master.sv
// hdmi_axil_cfg_master: turns single writes and sequential read bursts into AXI4-Lite transactions.
module hdmi_axil_cfg_master
  import hdmi_axil_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic              rsp_last,
  hdmi_axil_cfg_master_if.master m_axi
);
  state_e            r_state, w_state_n;
  logic              r_init;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, r_data;
  logic [LEN_W-1:0]  r_len, r_idx;
  logic              r_aw_done, r_w_done, r_b_done, r_err, r_last;
  logic              w_cmd_fire, w_aw_done, w_w_done, w_b_fire, w_b_done, w_ar_fire, w_r_fire;

  assign w_cmd_fire = cmd_valid && cmd_ready;
  assign w_aw_done  = r_aw_done || (m_axi.awvalid && m_axi.awready);
  assign w_w_done   = r_w_done || (m_axi.wvalid && m_axi.wready);
  assign w_b_fire   = m_axi.bvalid && m_axi.bready;
  assign w_b_done   = r_b_done || w_b_fire;
  assign w_ar_fire  = m_axi.arvalid && m_axi.arready;
  assign w_r_fire   = m_axi.rvalid && m_axi.rready;

  // r_init keeps cmd_ready low until the first edge after reset release
  assign cmd_ready     = r_init && r_state == IDLE;
  assign m_axi.awvalid = r_state == WR_ADDR_DATA && !r_aw_done;
  assign m_axi.wvalid  = r_state == WR_ADDR_DATA && !r_w_done;
  assign m_axi.awaddr  = r_addr;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = {4{r_state == WR_ADDR_DATA}};
  assign m_axi.bready  = (r_state == WR_ADDR_DATA || r_state == WR_RESP) && !r_b_done;
  assign m_axi.arvalid = r_state == RD_ADDR;
  assign m_axi.araddr  = r_addr + ADDR_W'({r_idx, 2'b00});
  assign m_axi.arprot  = 3'b000;
  assign m_axi.rready  = r_state == RD_DATA;
  assign rsp_valid     = r_state == RSP;
  assign rsp_data      = r_data;
  assign rsp_err       = r_err;
  assign rsp_last      = r_last;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_n;

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:         if (w_cmd_fire) w_state_n = cmd_addr[1:0] != 2'b00 ? RSP : cmd_write ? WR_ADDR_DATA : RD_ADDR;
      WR_ADDR_DATA: if (w_aw_done && w_w_done) w_state_n = w_b_done ? RSP : WR_RESP;
      WR_RESP:      if (w_b_fire) w_state_n = RSP;
      RD_ADDR:      if (w_ar_fire) w_state_n = RD_DATA;
      RD_DATA:      if (w_r_fire) w_state_n = RSP;
      RSP:          if (rsp_ready) w_state_n = r_last ? IDLE : RD_ADDR;
      default:      w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_init    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_b_done  <= 1'b0;
      r_data    <= '0;
      r_err     <= 1'b0;
      r_last    <= 1'b0;
    end else begin
      r_init <= 1'b1;
      if (w_cmd_fire) begin
        r_addr    <= cmd_addr;
        r_wdata   <= cmd_wdata;
        r_len     <= cmd_len;
        r_idx     <= '0;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_b_done  <= 1'b0;
        r_data    <= '0;
        r_err     <= cmd_addr[1:0] != 2'b00;
        r_last    <= 1'b1;
      end
      if (r_state == WR_ADDR_DATA) begin
        r_aw_done <= w_aw_done;
        r_w_done  <= w_w_done;
      end
      if (w_b_fire) begin
        r_b_done <= 1'b1;
        r_data   <= '0;
        r_err    <= m_axi.bresp != RESP_OKAY;
        r_last   <= 1'b1;
      end
      // errored read beats report zero data but the burst carries on
      if (w_r_fire) begin
        r_data <= m_axi.rresp != RESP_OKAY ? 32'h0 : m_axi.rdata;
        r_err  <= m_axi.rresp != RESP_OKAY;
        r_last <= r_idx == r_len;
      end
      if (r_state == RSP && rsp_ready && !r_last) r_idx <= r_idx + LEN_W'(1);
    end
endmodule

// File: doc/hdmi_axil_cfg_master.md
Name: hdmi_axil_cfg_master

Overview:
AXI4-Lite initiator that drives the register slave of the HDMI FIR/histogram IP. Local control logic (MicroBlaze-less test harness, boot loader, bench) issues simple commands: single-word writes (FIR coefficients, control) and multi-word sequential reads (histogram bins). The block converts each command into compliant AXI4-Lite transactions and returns one response beat per word. It sits between the configuration sequencer and the IP's AXI4-Lite slave port.

Parameters:
ADDR_W, 12, AXI address width in bits; byte address.
LEN_W, 8, width of cmd_len; a read burst moves cmd_len+1 words (max 2^LEN_W).

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  block idle, command accepted when both high
cmd_write  in  1  1 = single write, 0 = read burst
cmd_addr  in  ADDR_W  start byte address
cmd_wdata  in  32  write data (ignored for reads)
cmd_len  in  LEN_W  read words minus one (ignored for writes)
rsp_valid  out  1  response beat available
rsp_ready  in  1  consumer accepts beat
rsp_data  out  32  read data; 0 for writes and errors
rsp_err  out  1  beat failed (non-OKAY resp or misaligned)
rsp_last  out  1  final beat of the command
m_axi_awaddr/awprot/awvalid/awready  out/out/out/in  ADDR_W/3/1/1  write address channel
m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  write data channel
m_axi_bresp/bvalid/bready  in/in/out  2/1/1  write response channel
m_axi_araddr/arprot/arvalid/arready  out/out/out/in  ADDR_W/3/1/1  read address channel
m_axi_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  read data channel

Behaviour:
- Reset (async, rst_n=0): every output 0, state IDLE. cmd_ready rises on the first clk edge after release. Reset mid-transaction drops all valids immediately; no completion response is produced.
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE: cmd_ready=1. Handshake latches cmd_*; cmd_ready=0 from the next cycle. If cmd_addr[1:0]!=0 -> RSP with err=1, data=0, last=1. No AXI traffic.
- WR_ADDR_DATA: awvalid and wvalid rise the cycle after acceptance together, with awaddr=cmd_addr, wdata=cmd_wdata, wstrb=4'hF, awprot=0. Each valid drops the cycle after its own handshake; the channels complete in either order or together. bready=1 from entry until bvalid. When both are done -> WR_RESP (or straight to RSP if bvalid is already seen).
- WR_RESP: on bvalid&&bready -> RSP, err=(bresp!=2'b00), data=0, last=1.
- RD_ADDR: arvalid=1, araddr=base+4*idx (modulo 2^ADDR_W, wraps silently), arprot=0. Handshake -> RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata and err=(rresp!=0), last=(idx==cmd_len) -> RSP.
- RSP: rsp_valid=1 with data, err and last held stable until rsp_ready. On handshake: if it is not the last read beat, idx++ and go to RD_ADDR. Otherwise go to IDLE, and cmd_ready=1 the following cycle.
- A read error does not abort the burst. All remaining words are still fetched.
- Only one AXI transaction is outstanding at a time. Valids never drop before their handshake. Address, data and prot are stable while valid is high.
- Latency with an always-ready slave and bvalid/rvalid one cycle after the handshake: accept at T0, valid at T1, response at T2, rsp_valid at T3. One read beat takes 3 cycles plus rsp wait.
- rsp_ready held high in any state other than RSP has no effect.

Decomposition:
- Shared package hdmi_axil_pkg:
  - AXI resp codes OKAY/EXOKAY/SLVERR/DECERR.
  - State enum.
  - Register map constants: FIR coefficient base, histogram bin base, bin count, control register. These are shared with the slave side and the top-level IP.
- Sub-module: none. The block is one FSM plus the idx counter and response registers.

Test Plan:
- Write 0x0000_1234 to 0x010, slave always ready, bresp=OKAY at T2 -> aw/w at T1, wstrb=F, rsp_valid at T3 with err=0, last=1, data=0.
- Write with wready delayed 3 cycles after awready, bresp=SLVERR -> awvalid drops at T2, wvalid stays high until the handshake, rsp_err=1.
- Read burst addr 0x100, len=3, rdata=idx+0xA0, rsp_ready toggling 1/0 -> araddr 0x100, 0x104, 0x108, 0x10C; four beats A0..A3 each held while stalled; last only on A3.
- Read addr 0xFFC (ADDR_W=12), len=1, second rresp=DECERR -> araddr 0xFFC then 0x000; beat 1 err=0, beat 2 err=1 with last=1.
- Misaligned cmd_addr 0x102 -> no AXI valid ever rises; rsp err=1, last=1; cmd_ready high again after rsp handshake.
- rst_n pulsed low while arvalid is high -> all valids and rsp_valid go to 0 asynchronously, no response; cmd_ready=1 one cycle after release.
